// File: rtl/fifo_arb_ctrl.sv
// Round-robin write arbiter and read sequencer sharing one synchronous FIFO between
// NREQ producers and a single valid/ready consumer.
module fifo_arb_ctrl #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned CNT_W  = 5,
  localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic                     fifo_wr_en,
  output logic [DATA_W-1:0]        fifo_data_in,
  input  logic                     fifo_full,
  input  logic                     fifo_empty,
  output logic                     fifo_rd_en,
  input  logic [DATA_W-1:0]        fifo_data_out,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  input  logic                     out_ready,
  output logic [CNT_W-1:0]         occupancy,
  output logic [IDX_W-1:0]         last_grant
);

  localparam int unsigned SUM_W = IDX_W + 1;

  typedef enum logic [0:0] {StIdle, StValid} rd_state_e;

  rd_state_e        state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] last_grant_q, last_grant_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic [IDX_W-1:0] winner;
  logic             found;
  logic             wr_ok;
  logic             wr_fire;
  logic             rd_fire;

  // Scan offsets from the highest down so the nearest requester to rr_ptr wins last.
  always_comb begin : arb
    logic [SUM_W-1:0] cand;
    cand   = '0;
    winner = '0;
    found  = 1'b0;
    for (int unsigned k = NREQ; k > 0; k--) begin
      cand = {1'b0, rr_ptr_q} + SUM_W'(k - 1);
      if (cand >= SUM_W'(NREQ)) cand = cand - SUM_W'(NREQ);
      if (req_valid[cand[IDX_W-1:0]]) begin
        winner = cand[IDX_W-1:0];
        found  = 1'b1;
      end
    end
  end

  assign wr_ok   = (occ_q < CNT_W'(DEPTH)) & ~fifo_full;
  assign wr_fire = rst & wr_ok & found;
  assign rd_fire = rst & (occ_q != '0) & ~fifo_empty & ((state_q == StIdle) | out_ready);

  assign req_ready    = wr_fire ? (NREQ'(1) << winner) : '0;
  assign fifo_wr_en   = wr_fire;
  assign fifo_data_in = req_data[winner*DATA_W +: DATA_W];
  assign fifo_rd_en   = rd_fire;

  assign out_valid  = (state_q == StValid);
  assign out_data   = fifo_data_out;
  assign occupancy  = occ_q;
  assign last_grant = last_grant_q;

  always_comb begin
    state_d      = StIdle;
    rr_ptr_d     = rr_ptr_q;
    last_grant_d = last_grant_q;
    occ_d        = occ_q;

    if (rd_fire) begin
      state_d = StValid;
    end else if ((state_q == StValid) && !out_ready) begin
      state_d = StValid;
    end

    if (wr_fire) begin
      rr_ptr_d     = (winner == IDX_W'(NREQ - 1)) ? '0 : winner + 1'b1;
      last_grant_d = winner;
    end

    case ({wr_fire, rd_fire})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      rr_ptr_q     <= '0;
      last_grant_q <= '0;
      occ_q        <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      last_grant_q <= last_grant_d;
      occ_q        <= occ_d;
    end
  end

endmodule

// File: tb/tb_fifo_arb_ctrl.sv
// Bench for fifo_arb_ctrl: a 16x8 FIFO model, a queue-based reference model checked every
// cycle, directed scenarios with literal expectations, and randomized traffic.
module tb_fifo_arb_ctrl;

  localparam int unsigned NREQ   = 4;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned IDX_W  = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        req_ready;
  logic                   fifo_wr_en;
  logic [DATA_W-1:0]      fifo_data_in;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   fifo_rd_en;
  logic [DATA_W-1:0]      fifo_data_out;
  logic                   out_valid;
  logic [DATA_W-1:0]      out_data;
  logic                   out_ready;
  logic [CNT_W-1:0]       occupancy;
  logic [IDX_W-1:0]       last_grant;

  int errors = 0;
  int checks = 0;

  fifo_arb_ctrl #(
    .NREQ  (NREQ),
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_data_in (fifo_data_in),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_data_out(fifo_data_out),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .occupancy    (occupancy),
    .last_grant   (last_grant)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural 16x8 FIFO with a registered read port.
  logic [DATA_W-1:0] mem [DEPTH];
  int f_wp, f_rp, f_cnt;
  assign fifo_full  = (f_cnt == DEPTH);
  assign fifo_empty = (f_cnt == 0);

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      f_wp <= 0;
      f_rp <= 0;
      f_cnt <= 0;
      fifo_data_out <= '0;
    end else begin
      if (fifo_wr_en && f_cnt < DEPTH) begin
        mem[f_wp] <= fifo_data_in;
        f_wp <= (f_wp + 1) % DEPTH;
      end
      if (fifo_rd_en && f_cnt != 0) begin
        fifo_data_out <= mem[f_rp];
        f_rp <= (f_rp + 1) % DEPTH;
      end
      f_cnt <= f_cnt + ((fifo_wr_en && f_cnt < DEPTH) ? 1 : 0)
                     - ((fifo_rd_en && f_cnt != 0) ? 1 : 0);
    end
  end

  // Reference model: queue of stored words, presented word, round-robin pointer.
  int m_q[$];
  bit m_pv;
  int m_pd;
  int m_rr;
  int m_lg;

  always @(negedge clk) begin : model
    int w;
    bit found;
    bit e_wr;
    bit e_rd;
    int k;
    if (!rst) begin
      m_q.delete();
      m_pv = 1'b0;
      m_pd = 0;
      m_rr = 0;
      m_lg = 0;
      check("rst_req_ready", req_ready, 0);
      check("rst_wr_en", fifo_wr_en, 0);
      check("rst_rd_en", fifo_rd_en, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_occupancy", occupancy, 0);
    end else begin
      found = 1'b0;
      w = 0;
      for (k = 0; k < NREQ; k++) begin
        if (!found && req_valid[(m_rr + k) % NREQ]) begin
          found = 1'b1;
          w = (m_rr + k) % NREQ;
        end
      end
      e_wr = found && (m_q.size() < DEPTH);
      e_rd = (m_q.size() != 0) && (!m_pv || out_ready);
      check("req_ready", req_ready, e_wr ? (64'd1 << w) : 64'd0);
      check("fifo_wr_en", fifo_wr_en, e_wr);
      if (e_wr) check("fifo_data_in", fifo_data_in, req_data[w*DATA_W +: DATA_W]);
      check("fifo_rd_en", fifo_rd_en, e_rd);
      check("out_valid", out_valid, m_pv);
      if (m_pv) check("out_data", out_data, m_pd);
      check("occupancy", occupancy, m_q.size());
      check("last_grant", last_grant, m_lg);
      // Advance to the state after the coming rising edge.
      if (e_rd) m_pd = m_q.pop_front();
      if (e_wr) begin
        m_q.push_back(int'(req_data[w*DATA_W +: DATA_W]));
        m_rr = (w + 1) % NREQ;
        m_lg = w;
      end
      m_pv = e_rd ? 1'b1 : (m_pv && !out_ready);
    end
  end

  initial begin
    int w;
    int acc;
    int got[$];

    rst = 1'b0;
    req_valid = '0;
    req_data = '0;
    out_ready = 1'b0;
    repeat (3) tick();
    check("reset_last_grant", last_grant, 0);
    rst = 1'b1;

    // Fairness: all requesters, consumer always ready.
    req_valid = 4'hf;
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      for (int i = 0; i < NREQ; i++) req_data[i*DATA_W +: DATA_W] = 8'(16 * c + i);
      #1;
      check("fair_grant", req_ready, 64'd1 << (c % 4));
      if (c >= 2) begin
        check("fair_out_valid", out_valid, 1);
        check("fair_out_data", out_data, 16 * (c - 2) + ((c - 2) % 4));
      end
      tick();
    end
    req_valid = '0;
    repeat (6) tick();
    check("fair_drained_occ", occupancy, 0);
    check("fair_drained_valid", out_valid, 0);

    // Fill to full from requester 2 with the consumer stalled.
    out_ready = 1'b0;
    w = 1;
    acc = 0;
    for (int c = 0; c < 30; c++) begin
      req_valid = (w <= 20) ? 4'b0100 : 4'b0000;
      req_data = '0;
      req_data[2*DATA_W +: DATA_W] = 8'(w);
      #1;
      if (req_ready[2]) begin
        acc++;
        w++;
      end
      tick();
    end
    check("fill_accepted", acc, 17);
    check("fill_occupancy", occupancy, 16);
    check("fill_ready_low", req_ready[2], 0);
    check("fill_out_valid", out_valid, 1);
    check("fill_out_data", out_data, 8'h01);

    // Drain.
    req_valid = '0;
    out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (out_valid) got.push_back(int'(out_data));
      tick();
    end
    check("drain_count", got.size(), 17);
    for (int i = 0; i < got.size(); i++) check("drain_word", got[i], i + 1);
    check("drain_occ", occupancy, 0);
    check("drain_valid", out_valid, 0);

    // Simultaneous write and read at occupancy 8.
    out_ready = 1'b0;
    req_valid = 4'b0001;
    for (int c = 0; c < 9; c++) begin
      req_data[DATA_W-1:0] = 8'(8'h40 + c);
      tick();
    end
    check("occ8_reached", occupancy, 8);
    out_ready = 1'b1;
    for (int c = 9; c < 19; c++) begin
      req_data[DATA_W-1:0] = 8'(8'h40 + c);
      tick();
      check("occ8_steady", occupancy, 8);
    end
    req_valid = '0;
    repeat (20) tick();

    // Skip idle requesters starting from rr_ptr=2.
    req_valid = 4'b0010;
    tick();
    check("skip_setup_lg", last_grant, 1);
    req_valid = 4'b1010;
    #1;
    check("skip_grant0", req_ready, 4'b1000);
    tick();
    check("skip_lg0", last_grant, 3);
    check("skip_grant1", req_ready, 4'b0010);
    tick();
    check("skip_lg1", last_grant, 1);
    check("skip_grant2", req_ready, 4'b1000);
    tick();
    check("skip_lg2", last_grant, 3);
    req_valid = '0;
    repeat (4) tick();

    // Randomized traffic: a backpressured phase, then a mostly-ready phase.
    for (int c = 0; c < 1500; c++) begin
      req_valid = NREQ'($urandom);
      req_data = NREQ*DATA_W'($urandom);
      out_ready = (c < 750) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      tick();
    end

    // Asynchronous reset between clock edges while traffic is flowing.
    req_valid = 4'hf;
    out_ready = 1'b1;
    tick();
    tick();
    #2;
    rst = 1'b0;
    #1;
    check("async_req_ready", req_ready, 0);
    check("async_wr_en", fifo_wr_en, 0);
    check("async_rd_en", fifo_rd_en, 0);
    check("async_out_valid", out_valid, 0);
    check("async_occ", occupancy, 0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("post_reset_grant", req_ready, 4'b0001);
    check("post_reset_occ", occupancy, 0);
    tick();
    req_valid = '0;
    repeat (20) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
